// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: AND/OR/XOR/NOR of two operands, SLICE bits per
// cycle LSB first, with valid/ready handshakes on both sides and a registered zero flag.
module logic_unit_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  // WIDTH must be a multiple of SLICE.
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             zero_reg, zero_next;
  logic             accept;
  logic             run;

  function automatic logic [SLICE-1:0] slice_fn(input logic [1:0] o,
                                                input logic [SLICE-1:0] x,
                                                input logic [SLICE-1:0] y);
    logic [SLICE-1:0] r;
    case (o)
      2'b00:   r = x & y;
      2'b01:   r = x | y;
      2'b10:   r = x ^ y;
      default: r = ~(x | y);
    endcase
    return r;
  endfunction

  assign accept    = in_valid && (state_reg == IDLE);
  assign run       = (state_reg == RUN);
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign zero      = zero_reg;

  // Each slice of the result is cleared on accept and written only on its own RUN cycle.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
      logic [SLICE-1:0] slice_val;
      assign slice_val = slice_fn(op_reg, a_reg[gi*SLICE +: SLICE], b_reg[gi*SLICE +: SLICE]);
      assign result_next[gi*SLICE +: SLICE] =
          accept                         ? '0 :
          (run && cnt_reg == CW'(gi))    ? slice_val :
                                           result_reg[gi*SLICE +: SLICE];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    zero_next  = zero_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST) begin
          // result_next already holds the final slice here.
          zero_next  = (result_next == '0);
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      zero_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      result_reg <= result_next;
      zero_reg   <= zero_next;
      if (accept) begin
        op_reg <= op;
        a_reg  <= a;
        b_reg  <= b;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Scoreboard bench for logic_unit_seq: three instances (SLICE=8, 32, 1) share the
// operand bus; a negedge monitor pops expected results and checks data, zero and latency.
module tb_logic_unit_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_ready = 1'b1;
  logic [2:0]  in_valid_v = '0;
  logic [2:0]  in_ready_v;
  logic [2:0]  out_valid_v;
  logic [2:0]  zero_v;
  logic [31:0] result_v [3];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat_n [3] = '{4, 1, 32};

  typedef struct {
    int          inst;
    logic [31:0] res;
    logic        z;
  } exp_t;

  exp_t exp_q [$];
  int   acc_q [$];
  logic [2:0] seen = '0;
  int   first_cyc [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int SL = (gi == 0) ? 8 : ((gi == 1) ? 32 : 1);
      logic_unit_seq #(.WIDTH(32), .SLICE(SL)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid_v[gi]),
        .in_ready  (in_ready_v[gi]),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid_v[gi]),
        .out_ready (out_ready),
        .result    (result_v[gi]),
        .zero      (zero_v[gi])
      );
    end
  endgenerate

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, expv);
    end
  endtask

  // Monitor: detects accepts and completed output transfers.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (in_valid_v[i] && in_ready_v[i]) acc_q.push_back(cyc + 1);
      if (out_valid_v[i] && !seen[i]) begin
        seen[i] = 1'b1;
        first_cyc[i] = cyc;
      end
      if (out_valid_v[i] && out_ready) begin
        exp_t e;
        int   acc;
        seen[i] = 1'b0;
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output inst=%0d got=%h exp=none", i, result_v[i]);
        end else begin
          e   = exp_q.pop_front();
          acc = acc_q.pop_front();
          chk($sformatf("result inst=%0d", i), result_v[i], e.res);
          chk($sformatf("zero inst=%0d", i), {31'd0, zero_v[i]}, {31'd0, e.z});
          chk($sformatf("latency inst=%0d", i), first_cyc[i] - acc, lat_n[i]);
          $display("txn inst=%0d result=%h zero=%0b latency=%0d", i, result_v[i], zero_v[i],
                   first_cyc[i] - acc);
        end
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 of the accepting edge with in_valid still high.
  task automatic send(input int inst, input logic [1:0] o, input logic [31:0] aa,
                      input logic [31:0] bb, input logic [31:0] er, input logic ez);
    exp_t e;
    int   n;
    op = o;
    a  = aa;
    b  = bb;
    in_valid_v = '0;
    in_valid_v[inst] = 1'b1;
    e.inst = inst;
    e.res  = er;
    e.z    = ez;
    exp_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready_v[inst] && n < 100);
    if (!in_ready_v[inst]) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout inst=%0d got=in_ready0 exp=in_ready1", inst);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=%0d exp=0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    // Reset state, checked while reset is held.
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_in_ready inst=%0d", i), {31'd0, in_ready_v[i]}, 32'd1);
      chk($sformatf("rst_out_valid inst=%0d", i), {31'd0, out_valid_v[i]}, 32'd0);
      chk($sformatf("rst_result inst=%0d", i), result_v[i], 32'd0);
      chk($sformatf("rst_zero inst=%0d", i), {31'd0, zero_v[i]}, 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1. AND
    send(0, 2'b00, 32'hF0F0_1234, 32'hFF00_00FF, 32'hF000_0034, 1'b0);
    in_valid_v = '0;
    drain();

    // 2. NOR and XOR giving zero
    send(0, 2'b11, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1);
    in_valid_v = '0;
    drain();
    send(0, 2'b10, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 1'b1);
    in_valid_v = '0;
    drain();

    // 3. Backpressure in DONE
    out_ready = 1'b0;
    send(0, 2'b01, 32'h1234_5678, 32'h0F0F_0000, 32'h1F3F_5678, 1'b0);
    in_valid_v = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid_v[0] && n < 50);
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", {31'd0, out_valid_v[0]}, 32'd1);
      chk("bp_result", result_v[0], 32'h1F3F_5678);
      chk("bp_zero", {31'd0, zero_v[0]}, 32'd0);
      chk("bp_in_ready", {31'd0, in_ready_v[0]}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_xfer_in_ready", {31'd0, in_ready_v[0]}, 32'd0);
    @(negedge clk);
    chk("bp_after_in_ready", {31'd0, in_ready_v[0]}, 32'd1);
    chk("bp_after_out_valid", {31'd0, out_valid_v[0]}, 32'd0);
    drain();

    // 4. Inputs change during RUN with in_valid held high
    send(0, 2'b10, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0);
    send(0, 2'b00, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
    in_valid_v = '0;
    drain();

    // 5. Reset after two slices of RUN
    send(0, 2'b01, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0);
    in_valid_v = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("partial_result", result_v[0], 32'h0000_0003);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    @(negedge clk);
    chk("rst_run_out_valid", {31'd0, out_valid_v[0]}, 32'd0);
    chk("rst_run_result", result_v[0], 32'd0);
    chk("rst_run_in_ready", {31'd0, in_ready_v[0]}, 32'd1);
    @(posedge clk);
    #1;
    send(0, 2'b11, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
    in_valid_v = '0;
    drain();

    // 6. SLICE=32 (N=1) and SLICE=1 (N=32)
    send(1, 2'b01, 32'h8000_0001, 32'h0000_0100, 32'h8000_0101, 1'b0);
    in_valid_v = '0;
    drain();
    send(2, 2'b01, 32'h8000_0001, 32'h0000_0100, 32'h8000_0101, 1'b0);
    in_valid_v = '0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
